match_sequencer: RTL and testbench

MATCH_SEQUENCER -- requirements
Module: match_sequencer

---
 rtl/match_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_match_sequencer.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/match_sequencer.sv
// Match flow for a two-player paddle game: serve countdown, rally, point hold, game over.
// Build option AUTO_RESTART_EN: leave GAMEOVER for IDLE after 8 flash toggles.
module match_sequencer #(
    parameter int unsigned WIN_SCORE   = 7,
    parameter int unsigned SERVE_TICKS = 60,
    parameter int unsigned POINT_TICKS = 90,
    parameter int unsigned FLASH_TICKS = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start,
    input  logic       pause,
    input  logic       lossA,
    input  logic       lossB,
    output logic       game_en,
    output logic       ball_rst,
    output logic       serve_dir,
    output logic [2:0] scrA,
    output logic [2:0] scrB,
    output logic       gmv,
    output logic       gmv_flash,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SERVE    = 3'd1,
        S_PLAY     = 3'd2,
        S_PAUSED   = 3'd3,
        S_POINT    = 3'd4,
        S_GAMEOVER = 3'd5
    } state_t;

    localparam logic [2:0] WIN      = 3'(WIN_SCORE);
    localparam logic [7:0] SERVE_LD = 8'(SERVE_TICKS);
    localparam logic [7:0] POINT_LD = 8'(POINT_TICKS);
    localparam logic [7:0] FLASH_LD = 8'(FLASH_TICKS);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] scr_a_q, scr_a_d;
    logic [2:0] scr_b_q, scr_b_d;
    logic       dir_q, dir_d;
    logic       ball_q, ball_d;
    logic       gmv_q, gmv_d;
    logic       flash_q, flash_d;
    logic       game_en_q, game_en_d;
    logic       start_q, start_d;
    logic       start_rise;
`ifdef AUTO_RESTART_EN
    logic [2:0] flips_q, flips_d;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        scr_a_d    = scr_a_q;
        scr_b_d    = scr_b_q;
        dir_d      = dir_q;
        ball_d     = 1'b0;
        gmv_d      = gmv_q;
        flash_d    = flash_q;
        start_d    = start;
        game_en_d  = tick && (state_q == S_PLAY);
        start_rise = start && !start_q;
`ifdef AUTO_RESTART_EN
        flips_d    = flips_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start_rise) begin
                    scr_a_d = 3'd0;
                    scr_b_d = 3'd0;
                    ball_d  = 1'b1;
                    cnt_d   = SERVE_LD;
                    state_d = S_SERVE;
                end
            end
            S_SERVE: begin
                if (tick && !pause) begin
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) state_d = S_PLAY;
                end
            end
            S_PLAY: begin
                // a simultaneous double loss is a void rally
                if (lossA && lossB) begin
                    cnt_d   = POINT_LD;
                    state_d = S_POINT;
                end else if (lossA) begin
                    if (scr_b_q < WIN) scr_b_d = scr_b_q + 3'd1;
                    dir_d   = 1'b0;
                    cnt_d   = POINT_LD;
                    state_d = S_POINT;
                end else if (lossB) begin
                    if (scr_a_q < WIN) scr_a_d = scr_a_q + 3'd1;
                    dir_d   = 1'b1;
                    cnt_d   = POINT_LD;
                    state_d = S_POINT;
                end else if (pause) begin
                    state_d = S_PAUSED;
                end
            end
            S_PAUSED: begin
                if (!pause) state_d = S_PLAY;
            end
            S_POINT: begin
                if (tick) begin
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        if (scr_a_q == WIN || scr_b_q == WIN) begin
                            gmv_d   = 1'b1;
                            flash_d = 1'b1;
                            cnt_d   = FLASH_LD;
                            state_d = S_GAMEOVER;
`ifdef AUTO_RESTART_EN
                            flips_d = 3'd0;
`endif
                        end else begin
                            ball_d  = 1'b1;
                            cnt_d   = SERVE_LD;
                            state_d = S_SERVE;
                        end
                    end
                end
            end
            S_GAMEOVER: begin
                if (start_rise) begin
                    scr_a_d = 3'd0;
                    scr_b_d = 3'd0;
                    ball_d  = 1'b1;
                    gmv_d   = 1'b0;
                    flash_d = 1'b0;
                    cnt_d   = SERVE_LD;
                    state_d = S_SERVE;
                end else if (tick) begin
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        flash_d = !flash_q;
                        cnt_d   = FLASH_LD;
`ifdef AUTO_RESTART_EN
                        flips_d = flips_q + 3'd1;
                        if (flips_q == 3'd7) begin
                            scr_a_d = 3'd0;
                            scr_b_d = 3'd0;
                            gmv_d   = 1'b0;
                            flash_d = 1'b0;
                            cnt_d   = 8'd0;
                            state_d = S_IDLE;
                        end
`endif
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 8'd0;
            scr_a_q   <= 3'd0;
            scr_b_q   <= 3'd0;
            dir_q     <= 1'b0;
            ball_q    <= 1'b0;
            gmv_q     <= 1'b0;
            flash_q   <= 1'b0;
            game_en_q <= 1'b0;
            start_q   <= 1'b0;
`ifdef AUTO_RESTART_EN
            flips_q   <= 3'd0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            scr_a_q   <= scr_a_d;
            scr_b_q   <= scr_b_d;
            dir_q     <= dir_d;
            ball_q    <= ball_d;
            gmv_q     <= gmv_d;
            flash_q   <= flash_d;
            game_en_q <= game_en_d;
            start_q   <= start_d;
`ifdef AUTO_RESTART_EN
            flips_q   <= flips_d;
`endif
        end
    end

    assign game_en   = game_en_q;
    assign ball_rst  = ball_q;
    assign serve_dir = dir_q;
    assign scrA      = scr_a_q;
    assign scrB      = scr_b_q;
    assign gmv       = gmv_q;
    assign gmv_flash = flash_q;
    assign state     = state_q;

endmodule

// File: tb/tb_match_sequencer.sv
// Self-checking bench for match_sequencer: directed scenarios plus a randomized
// run compared every cycle against a rule-level model of the match.
module tb_match_sequencer;

    localparam int WIN = 2;
    localparam int SRV = 3;
    localparam int PNT = 4;
    localparam int FLS = 2;

    localparam int PH_IDLE  = 0;
    localparam int PH_SERVE = 1;
    localparam int PH_PLAY  = 2;
    localparam int PH_PAUSE = 3;
    localparam int PH_POINT = 4;
    localparam int PH_OVER  = 5;

    logic       clk = 1'b0;
    logic       rst, tick, start, pause, lossA, lossB;
    logic       game_en, ball_rst, serve_dir, gmv, gmv_flash;
    logic [2:0] scrA, scrB, state;

    int tests = 0;
    int fails = 0;
    int nball = 0;

    int ph, left, ma, mb, flips;
    bit mdir, mball, mgmv, mflash, mgen, mprev;

    always #5 clk = ~clk;

    match_sequencer #(
        .WIN_SCORE  (WIN),
        .SERVE_TICKS(SRV),
        .POINT_TICKS(PNT),
        .FLASH_TICKS(FLS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .start    (start),
        .pause    (pause),
        .lossA    (lossA),
        .lossB    (lossB),
        .game_en  (game_en),
        .ball_rst (ball_rst),
        .serve_dir(serve_dir),
        .scrA     (scrA),
        .scrB     (scrB),
        .gmv      (gmv),
        .gmv_flash(gmv_flash),
        .state    (state)
    );

    task automatic model_new_match();
        ma    = 0;
        mb    = 0;
        mball = 1;
        left  = SRV;
        ph    = PH_SERVE;
    endtask

    // Applies the match rules to one clock edge using the inputs held at it.
    task automatic model_update();
        bit rise;
        rise  = start && !mprev;
        mprev = start;
        mball = 0;
        mgen  = tick && (ph == PH_PLAY);
        if (rst) begin
            ph = PH_IDLE; left = 0; ma = 0; mb = 0; flips = 0;
            mdir = 0; mgmv = 0; mflash = 0; mprev = 0; mgen = 0;
            return;
        end
        if (ph == PH_IDLE) begin
            if (rise) model_new_match();
        end else if (ph == PH_SERVE) begin
            if (tick && !pause) begin
                left = left - 1;
                if (left == 0) ph = PH_PLAY;
            end
        end else if (ph == PH_PLAY) begin
            if (lossA || lossB) begin
                if (lossA && !lossB) begin
                    mb = (mb < WIN) ? mb + 1 : mb;
                    mdir = 0;
                end
                if (lossB && !lossA) begin
                    ma = (ma < WIN) ? ma + 1 : ma;
                    mdir = 1;
                end
                ph = PH_POINT;
                left = PNT;
            end else if (pause) begin
                ph = PH_PAUSE;
            end
        end else if (ph == PH_PAUSE) begin
            if (!pause) ph = PH_PLAY;
        end else if (ph == PH_POINT) begin
            if (tick) begin
                left = left - 1;
                if (left == 0) begin
                    if (ma == WIN || mb == WIN) begin
                        ph = PH_OVER; mgmv = 1; mflash = 1;
                        left = FLS; flips = 0;
                    end else begin
                        mball = 1; left = SRV; ph = PH_SERVE;
                    end
                end
            end
        end else begin
            if (rise) begin
                model_new_match();
                mgmv = 0;
                mflash = 0;
            end else if (tick) begin
                left = left - 1;
                if (left == 0) begin
                    mflash = !mflash;
                    left = FLS;
                    flips++;
`ifdef AUTO_RESTART_EN
                    if (flips == 8) begin
                        ph = PH_IDLE; ma = 0; mb = 0; mgmv = 0; mflash = 0;
                    end
`endif
                end
            end
        end
    endtask

    task automatic step(input bit t, input bit s, input bit p,
                        input bit la, input bit lb, input bit r);
        @(negedge clk);
        tick = t; start = s; pause = p; lossA = la; lossB = lb; rst = r;
        @(posedge clk);
        model_update();
        #1;
        if (ball_rst === 1'b1) nball++;
    endtask

    task automatic tick4(input bit p);
        step(1, 0, p, 0, 0, 0);
        repeat (3) step(0, 0, p, 0, 0, 0);
    endtask

    task automatic drive_to_gameover();
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        repeat (SRV) tick4(0);
        step(0, 0, 0, 1, 0, 0);
        repeat (PNT) tick4(0);
        repeat (SRV) tick4(0);
        step(0, 0, 0, 1, 0, 0);
        repeat (PNT) tick4(0);
    endtask

    task automatic test_reset();
        step(1, 1, 1, 1, 1, 1);
        step(1, 0, 0, 1, 0, 1);
        tests++;
        if ({state, scrA, scrB, serve_dir, ball_rst, gmv, gmv_flash, game_en} !== 14'd0) begin
            fails++;
            $display("FAIL reset_vals got state=%0d a=%0d b=%0d dir=%b br=%b gmv=%b fl=%b en=%b exp all 0",
                     state, scrA, scrB, serve_dir, ball_rst, gmv, gmv_flash, game_en);
        end
        step(1, 0, 0, 0, 0, 0);
        tests++;
        if (game_en !== 1'b0 || state !== 3'd0) begin
            fails++;
            $display("FAIL reset_release got en=%b state=%0d exp en=0 state=0", game_en, state);
        end
    endtask

    task automatic test_serve();
        nball = 0;
        step(0, 1, 0, 0, 0, 0);
        tests++;
        if (state !== 3'd1 || ball_rst !== 1'b1 || scrA !== 3'd0 || scrB !== 3'd0) begin
            fails++;
            $display("FAIL serve_entry got state=%0d br=%b a=%0d b=%0d exp 1 1 0 0",
                     state, ball_rst, scrA, scrB);
        end
        step(0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= SRV; i++) begin
            tick4(0);
            tests++;
            if (state !== ((i == SRV) ? 3'd2 : 3'd1) || game_en !== 1'b0) begin
                fails++;
                $display("FAIL serve_tick%0d got state=%0d en=%b", i, state, game_en);
            end
        end
        tests++;
        if (nball != 1) begin
            fails++;
            $display("FAIL serve_ball_once got %0d pulses exp 1", nball);
        end
        step(1, 0, 0, 0, 0, 0);
        tests++;
        if (game_en !== 1'b1) begin
            fails++;
            $display("FAIL play_en_tick got %b exp 1", game_en);
        end
        step(0, 0, 0, 0, 0, 0);
        tests++;
        if (game_en !== 1'b0) begin
            fails++;
            $display("FAIL play_en_idle got %b exp 0", game_en);
        end
    endtask

    task automatic test_point();
        step(0, 0, 0, 0, 1, 0);
        tests++;
        if (state !== 3'd4 || scrA !== 3'd1 || scrB !== 3'd0 || serve_dir !== 1'b1) begin
            fails++;
            $display("FAIL point_lossB got state=%0d a=%0d b=%0d dir=%b exp 4 1 0 1",
                     state, scrA, scrB, serve_dir);
        end
        repeat (PNT - 1) tick4(0);
        tests++;
        if (state !== 3'd4) begin
            fails++;
            $display("FAIL point_hold got state=%0d exp 4", state);
        end
        step(1, 0, 0, 0, 0, 0);
        tests++;
        if (state !== 3'd1 || ball_rst !== 1'b1) begin
            fails++;
            $display("FAIL point_exit got state=%0d br=%b exp 1 1", state, ball_rst);
        end
        repeat (3) step(0, 0, 0, 0, 0, 0);
        repeat (5) tick4(1);
        tests++;
        if (state !== 3'd1) begin
            fails++;
            $display("FAIL serve_pause_freeze got state=%0d exp 1", state);
        end
        repeat (SRV) tick4(0);
        tests++;
        if (state !== 3'd2) begin
            fails++;
            $display("FAIL serve_after_pause got state=%0d exp 2", state);
        end
    endtask

    task automatic test_both_loss();
        step(0, 0, 0, 1, 1, 0);
        tests++;
        if (state !== 3'd4 || scrA !== 3'd1 || scrB !== 3'd0 || serve_dir !== 1'b1) begin
            fails++;
            $display("FAIL both_loss got state=%0d a=%0d b=%0d dir=%b exp 4 1 0 1",
                     state, scrA, scrB, serve_dir);
        end
        repeat (PNT) tick4(0);
        repeat (SRV) tick4(0);
        step(0, 0, 1, 1, 0, 0);
        tests++;
        if (state !== 3'd4 || scrB !== 3'd1 || serve_dir !== 1'b0) begin
            fails++;
            $display("FAIL loss_over_pause got state=%0d b=%0d dir=%b exp 4 1 0",
                     state, scrB, serve_dir);
        end
        step(0, 0, 0, 0, 0, 0);
        repeat (PNT) tick4(0);
        repeat (SRV) tick4(0);
        tests++;
        if (state !== 3'd2) begin
            fails++;
            $display("FAIL back_to_play got state=%0d exp 2", state);
        end
    endtask

    task automatic test_pause();
        step(0, 0, 1, 0, 0, 0);
        tests++;
        if (state !== 3'd3) begin
            fails++;
            $display("FAIL pause_enter got state=%0d exp 3", state);
        end
        step(1, 0, 1, 1, 0, 0);
        step(1, 0, 1, 0, 1, 0);
        tests++;
        if (state !== 3'd3 || scrA !== 3'd1 || scrB !== 3'd1 || game_en !== 1'b0) begin
            fails++;
            $display("FAIL pause_loss got state=%0d a=%0d b=%0d en=%b exp 3 1 1 0",
                     state, scrA, scrB, game_en);
        end
        step(0, 0, 0, 0, 0, 0);
        tests++;
        if (state !== 3'd2) begin
            fails++;
            $display("FAIL pause_exit got state=%0d exp 2", state);
        end
    endtask

    task automatic test_gameover();
        step(0, 0, 0, 1, 0, 0);
        repeat (PNT) tick4(0);
        tests++;
        if (state !== 3'd5 || scrB !== 3'd2 || gmv !== 1'b1 || gmv_flash !== 1'b1) begin
            fails++;
            $display("FAIL gameover_enter got state=%0d b=%0d gmv=%b fl=%b exp 5 2 1 1",
                     state, scrB, gmv, gmv_flash);
        end
        repeat (FLS) tick4(0);
        tests++;
        if (gmv_flash !== 1'b0 || gmv !== 1'b1) begin
            fails++;
            $display("FAIL flash_toggle1 got fl=%b gmv=%b exp 0 1", gmv_flash, gmv);
        end
        repeat (FLS) tick4(0);
        tests++;
        if (gmv_flash !== 1'b1) begin
            fails++;
            $display("FAIL flash_toggle2 got fl=%b exp 1", gmv_flash);
        end
        step(0, 1, 0, 0, 0, 0);
        tests++;
        if (state !== 3'd1 || scrA !== 3'd0 || scrB !== 3'd0 || gmv !== 1'b0 ||
            gmv_flash !== 1'b0 || ball_rst !== 1'b1) begin
            fails++;
            $display("FAIL restart got state=%0d a=%0d b=%0d gmv=%b fl=%b br=%b exp 1 0 0 0 0 1",
                     state, scrA, scrB, gmv, gmv_flash, ball_rst);
        end
        step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_auto_restart();
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0);
        drive_to_gameover();
        tests++;
        if (state !== 3'd5) begin
            fails++;
            $display("FAIL reach_gameover got state=%0d exp 5", state);
        end
        repeat (8 * FLS) tick4(0);
        tests++;
`ifdef AUTO_RESTART_EN
        if (state !== 3'd0 || scrB !== 3'd0 || gmv !== 1'b0 || gmv_flash !== 1'b0) begin
            fails++;
            $display("FAIL auto_idle got state=%0d b=%0d gmv=%b fl=%b exp 0 0 0 0",
                     state, scrB, gmv, gmv_flash);
        end
`else
        if (state !== 3'd5 || gmv !== 1'b1 || gmv_flash !== 1'b1) begin
            fails++;
            $display("FAIL gameover_stays got state=%0d gmv=%b fl=%b exp 5 1 1",
                     state, gmv, gmv_flash);
        end
`endif
    endtask

    task automatic test_reset_mid();
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        tick4(0);
        step(1, 0, 1, 1, 0, 1);
        tests++;
        if ({state, scrA, scrB, serve_dir, ball_rst, gmv, gmv_flash, game_en} !== 14'd0) begin
            fails++;
            $display("FAIL rst_mid_serve got state=%0d br=%b en=%b exp all 0",
                     state, ball_rst, game_en);
        end
        step(0, 0, 0, 0, 0, 0);
        drive_to_gameover();
        tick4(0);
        step(1, 0, 0, 0, 0, 1);
        tests++;
        if ({state, scrA, scrB, serve_dir, ball_rst, gmv, gmv_flash, game_en} !== 14'd0) begin
            fails++;
            $display("FAIL rst_mid_over got state=%0d b=%0d gmv=%b fl=%b exp all 0",
                     state, scrB, gmv, gmv_flash);
        end
    endtask

    task automatic test_random();
        bit s, p;
        logic [13:0] act, exp;
        s = 0;
        p = 0;
        step(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 19) == 0) s = !s;
            if ($urandom_range(0, 14) == 0) p = !p;
            step($urandom_range(0, 2) == 0, s, p,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 599) == 0);
            act = {state, scrA, scrB, serve_dir, ball_rst, gmv, gmv_flash, game_en};
            exp = {3'(ph), 3'(ma), 3'(mb), mdir, mball, mgmv, mflash, mgen};
            tests++;
            if (act !== exp) begin
                fails++;
                $display("FAIL random_cycle%0d got %b exp %b", i, act, exp);
            end
        end
    endtask

    initial begin
        rst = 1; tick = 0; start = 0; pause = 0; lossA = 0; lossB = 0;
        ph = PH_IDLE; left = 0; ma = 0; mb = 0; flips = 0;
        mdir = 0; mball = 0; mgmv = 0; mflash = 0; mgen = 0; mprev = 0;
        test_reset();
        test_serve();
        test_point();
        test_both_loss();
        test_pause();
        test_gameover();
        test_auto_restart();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
